// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : id_ex_stage                                                  |
// | Description : RV32I ID/EX pipeline latch with WB->ID bypass, load-use      |
// |               stall/bubble, branch flush and saturating event counters.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module id_ex_stage #(
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [31:0]       id_pc,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic [31:0]       id_imm,
   input  logic              id_mem_read,
   input  logic              id_reg_write,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [31:0]       rf_data1,
   input  logic [31:0]       rf_data2,
   input  logic              wb_we,
   input  logic [4:0]        wb_rd,
   input  logic [31:0]       wb_data,
   input  logic              flush,
   output logic              stall_if,
   output logic              ex_valid,
   output logic [31:0]       ex_pc,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [31:0]       ex_imm,
   output logic [31:0]       ex_op1,
   output logic [31:0]       ex_op2,
   output logic              ex_mem_read,
   output logic              ex_reg_write,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   logic              r_valid;
   logic [31:0]       r_pc;
   logic [4:0]        r_rs1;
   logic [4:0]        r_rs2;
   logic [4:0]        r_rd;
   logic [31:0]       r_imm;
   logic [31:0]       r_op1;
   logic [31:0]       r_op2;
   logic              r_mem_read;
   logic              r_reg_write;
   logic [CTRL_W-1:0] r_ctrl;
   logic [CNT_W-1:0]  r_bubble_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;

   logic [31:0]       w_op1;
   logic [31:0]       w_op2;
   logic              w_load_use;
   logic              w_squash;

   // The register file reads combinationally, so a same-cycle WB write must be bypassed here.
   always_comb begin
      w_op1 = rf_data1;
      if (id_rs1 == 5'd0)
         w_op1 = 32'd0;
      else if (wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs1))
         w_op1 = wb_data;
   end

   always_comb begin
      w_op2 = rf_data2;
      if (id_rs2 == 5'd0)
         w_op2 = 32'd0;
      else if (wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs2))
         w_op2 = wb_data;
   end

   assign w_load_use = r_valid && r_mem_read && (r_rd != 5'd0) && id_valid &&
                       ((r_rd == id_rs1) || (r_rd == id_rs2));
   assign w_squash   = flush || w_load_use;
   assign stall_if   = w_load_use && !flush;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid      <= 1'b0;
         r_pc         <= 32'd0;
         r_rs1        <= 5'd0;
         r_rs2        <= 5'd0;
         r_rd         <= 5'd0;
         r_imm        <= 32'd0;
         r_op1        <= 32'd0;
         r_op2        <= 32'd0;
         r_mem_read   <= 1'b0;
         r_reg_write  <= 1'b0;
         r_ctrl       <= '0;
         r_bubble_cnt <= '0;
         r_flush_cnt  <= '0;
      end else begin
         if (w_squash) begin
            // Bubble: every field zeroed so EX sees a clean NOP.
            r_valid     <= 1'b0;
            r_pc        <= 32'd0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_imm       <= 32'd0;
            r_op1       <= 32'd0;
            r_op2       <= 32'd0;
            r_mem_read  <= 1'b0;
            r_reg_write <= 1'b0;
            r_ctrl      <= '0;
         end else begin
            r_valid     <= id_valid;
            r_pc        <= id_pc;
            r_rs1       <= id_rs1;
            r_rs2       <= id_rs2;
            r_rd        <= id_rd;
            r_imm       <= id_imm;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_mem_read  <= id_mem_read;
            r_reg_write <= id_reg_write;
            r_ctrl      <= id_ctrl;
         end

         // A flush that coincides with a load-use hazard is accounted as a flush only.
         if (flush) begin
            if (r_flush_cnt != c_cnt_max)
               r_flush_cnt <= r_flush_cnt + c_cnt_one;
         end else if (w_load_use) begin
            if (r_bubble_cnt != c_cnt_max)
               r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
         end
      end
   end

   assign ex_valid     = r_valid;
   assign ex_pc        = r_pc;
   assign ex_rs1       = r_rs1;
   assign ex_rs2       = r_rs2;
   assign ex_rd        = r_rd;
   assign ex_imm       = r_imm;
   assign ex_op1       = r_op1;
   assign ex_op2       = r_op2;
   assign ex_mem_read  = r_mem_read;
   assign ex_reg_write = r_reg_write;
   assign ex_ctrl      = r_ctrl;
   assign bubble_cnt   = r_bubble_cnt;
   assign flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire
